mem_port_arbiter: RTL and testbench

- Shares the single data-side port of the 1 MiB RAM between the instruction-fetch requester and the load/store requester.
- Each side gets a valid/ready request channel and a valid/ready response channel. One transaction is in flight at a time.
- Data requests have fixed priority. A starvation guard forces an instruction grant after a bounded run of data grants.
- Sits between the core front-end/LSU and the RAM. Drives the RAM's enable, addr, data, memo and mask inputs; consumes its resp and dException outputs.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM data port between instruction fetch and load/store.
// One transaction in flight: IDLE (grant) -> ACCESS (1 cycle, RAM enabled) -> RESP (hold until consumed).
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [63:0] i_req_addr,
    output logic        i_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] i_resp_instr,
    output logic [1:0]  i_resp_exc,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [63:0] d_req_addr,
    input  logic [63:0] d_req_data,
    input  logic [1:0]  d_req_memo,
    input  logic [7:0]  d_req_mask,
    output logic        d_resp_valid,
    input  logic        d_resp_ready,
    output logic [63:0] d_resp_data,
    output logic [1:0]  d_resp_exc,

    output logic        m_enable,
    output logic [63:0] m_addr,
    output logic [63:0] m_data,
    output logic [1:0]  m_memo,
    output logic [7:0]  m_mask,
    input  logic [63:0] m_resp,
    input  logic [1:0]  m_exc
);

    // Handshake rule for all four channels: a transfer happens on the rising
    // edge where valid && ready are both 1; the sender holds valid and its
    // payload stable until then, and the arbiter never withdraws ready early.

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_data_q, owner_data_d;
    logic [CNT_W-1:0]  streak_q, streak_d;

    logic [63:0]       m_addr_q, m_addr_d;
    logic [63:0]       m_data_q, m_data_d;
    logic [1:0]        m_memo_q, m_memo_d;
    logic [7:0]        m_mask_q, m_mask_d;

    logic [31:0]       i_instr_q, i_instr_d;
    logic [1:0]        i_exc_q, i_exc_d;
    logic [63:0]       d_data_q, d_data_d;
    logic [1:0]        d_exc_q, d_exc_d;

    logic              starve;
    logic              grant_d;
    logic              grant_i;

    // A pending fetch that has watched LIMIT data grants in a row takes precedence.
    assign starve  = i_req_valid && (streak_q == LIMIT);
    assign grant_d = d_req_valid && !starve;
    assign grant_i = !grant_d && i_req_valid;

    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        streak_d     = streak_q;
        m_addr_d     = m_addr_q;
        m_data_d     = m_data_q;
        m_memo_d     = m_memo_q;
        m_mask_d     = m_mask_q;
        i_instr_d    = i_instr_q;
        i_exc_d      = i_exc_q;
        d_data_d     = d_data_q;
        d_exc_d      = d_exc_q;
        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    d_req_ready  = 1'b1;
                    owner_data_d = 1'b1;
                    m_addr_d     = d_req_addr;
                    m_data_d     = d_req_data;
                    m_memo_d     = d_req_memo;
                    m_mask_d     = d_req_mask;
                    if (!i_req_valid) begin
                        streak_d = '0;
                    end else if (streak_q != LIMIT) begin
                        streak_d = streak_q + 1'b1;
                    end
                    state_d = S_ACCESS;
                end else if (grant_i) begin
                    i_req_ready  = 1'b1;
                    owner_data_d = 1'b0;
                    m_addr_d     = i_req_addr;
                    m_data_d     = '0;
                    m_memo_d     = 2'b00;
                    m_mask_d     = 8'hFF;
                    streak_d     = '0;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (owner_data_q) begin
                    d_data_d = m_resp;
                    d_exc_d  = m_exc;
                end else begin
                    i_instr_d = m_resp[31:0];
                    // Out-of-bounds from the RAM outranks fetch misalignment.
                    if (m_exc == 2'b10) begin
                        i_exc_d = 2'b10;
                    end else if (m_addr_q[0]) begin
                        i_exc_d = 2'b01;
                    end else begin
                        i_exc_d = 2'b00;
                    end
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (owner_data_q ? d_resp_ready : i_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_data_q <= 1'b1;
            streak_q     <= '0;
            m_addr_q     <= '0;
            m_data_q     <= '0;
            m_memo_q     <= '0;
            m_mask_q     <= '0;
            i_instr_q    <= '0;
            i_exc_q      <= '0;
            d_data_q     <= '0;
            d_exc_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            streak_q     <= streak_d;
            m_addr_q     <= m_addr_d;
            m_data_q     <= m_data_d;
            m_memo_q     <= m_memo_d;
            m_mask_q     <= m_mask_d;
            i_instr_q    <= i_instr_d;
            i_exc_q      <= i_exc_d;
            d_data_q     <= d_data_d;
            d_exc_q      <= d_exc_d;
        end
    end

    // Enable decodes straight from the state flop so reset kills a write at once.
    assign m_enable     = (state_q == S_ACCESS);
    assign m_addr       = m_addr_q;
    assign m_data       = m_data_q;
    assign m_memo       = m_memo_q;
    assign m_mask       = m_mask_q;

    assign i_resp_valid = (state_q == S_RESP) && !owner_data_q;
    assign i_resp_instr = i_instr_q;
    assign i_resp_exc   = i_exc_q;
    assign d_resp_valid = (state_q == S_RESP) && owner_data_q;
    assign d_resp_data  = d_data_q;
    assign d_resp_exc   = d_exc_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array RAM stand-in, transaction-age reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req_valid = 1'b0, i_req_ready, i_resp_valid, i_resp_ready = 1'b1;
    logic [63:0] i_req_addr = '0;
    logic [31:0] i_resp_instr;
    logic [1:0]  i_resp_exc;
    logic        d_req_valid = 1'b0, d_req_ready, d_resp_valid, d_resp_ready = 1'b1;
    logic [63:0] d_req_addr = '0, d_req_data = '0, d_resp_data;
    logic [1:0]  d_req_memo = '0, d_resp_exc;
    logic [7:0]  d_req_mask = '0;
    logic        m_enable;
    logic [63:0] m_addr, m_data;
    logic [1:0]  m_memo;
    logic [7:0]  m_mask;
    logic [63:0] m_resp = '0;
    logic [1:0]  m_exc = '0;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
        .i_resp_instr(i_resp_instr), .i_resp_exc(i_resp_exc),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_data(d_req_data), .d_req_memo(d_req_memo), .d_req_mask(d_req_mask),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
        .d_resp_data(d_resp_data), .d_resp_exc(d_resp_exc),
        .m_enable(m_enable), .m_addr(m_addr), .m_data(m_data), .m_memo(m_memo),
        .m_mask(m_mask), .m_resp(m_resp), .m_exc(m_exc)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM stand-in ----------------
    // 1 MiB window; bit 31 is an alias so 0x8000_0000.. maps onto the same bytes.
    logic [7:0] ram [0:1048575];

    function automatic logic ram_oob(input logic [63:0] a);
        return (a[63:32] != '0) || (a[30:20] != '0);
    endfunction

    function automatic logic [63:0] ram_peek(input logic [63:0] a);
        logic [63:0] r;
        logic [19:0] idx;
        r = '0;
        if (!ram_oob(a)) begin
            for (int b = 0; b < 8; b++) begin
                idx = a[19:0] + 20'(b);
                r[8*b +: 8] = ram[idx];
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        m_resp = m_memo[0] ? 64'd0 : ram_peek(m_addr);
        m_exc  = ram_oob(m_addr) ? 2'b10 : 2'b00;
    end

    always @(posedge clk) begin
        if (m_enable && m_memo[0] && !ram_oob(m_addr)) begin
            for (int b = 0; b < 8; b++) begin
                if (m_mask[b]) ram[m_addr[19:0] + 20'(b)] = m_data[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // age = cycles since the grant edge (-1 when no transaction is open).
    int          age = -1;
    logic        mdl_owner_d = 1'b1;
    int          mdl_streak = 0;
    logic [63:0] ea = '0, ed = '0;
    logic [1:0]  em = '0;
    logic [7:0]  emk = '0;
    logic [31:0] exp_instr = '0;
    logic [1:0]  exp_iexc = '0, exp_dexc = '0;
    logic [63:0] exp_ddata = '0;

    function automatic logic mdl_data_wins();
        return d_req_valid && !(i_req_valid && mdl_streak == STARVE_LIMIT);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            age = -1; mdl_owner_d = 1'b1; mdl_streak = 0;
            ea = '0; ed = '0; em = '0; emk = '0;
            exp_instr = '0; exp_iexc = '0; exp_dexc = '0; exp_ddata = '0;
        end else if (age < 0) begin
            if (mdl_data_wins()) begin
                mdl_owner_d = 1'b1;
                ea = d_req_addr; ed = d_req_data; em = d_req_memo; emk = d_req_mask;
                mdl_streak = i_req_valid ? ((mdl_streak + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mdl_streak + 1) : 0;
                age = 1;
            end else if (i_req_valid) begin
                mdl_owner_d = 1'b0;
                ea = i_req_addr; ed = '0; em = 2'b00; emk = 8'hFF;
                mdl_streak = 0;
                age = 1;
            end
        end else if (age == 1) begin
            if (mdl_owner_d) begin
                exp_ddata = em[0] ? 64'd0 : ram_peek(ea);
                exp_dexc  = ram_oob(ea) ? 2'b10 : 2'b00;
            end else begin
                exp_instr = ram_peek(ea) >> 0;
                exp_iexc  = ram_oob(ea) ? 2'b10 : (ea[0] ? 2'b01 : 2'b00);
            end
            age = 2;
        end else begin
            if (mdl_owner_d ? d_resp_ready : i_resp_ready) age = -1;
        end
    end

    always @(negedge clk) begin
        chk("i_req_ready", i_req_ready, age < 0 && !mdl_data_wins() && i_req_valid);
        chk("d_req_ready", d_req_ready, age < 0 && mdl_data_wins());
        chk("m_enable", m_enable, age == 1);
        chk("m_addr", m_addr, ea);
        chk("m_data", m_data, ed);
        chk("m_memo", m_memo, em);
        chk("m_mask", m_mask, emk);
        chk("i_resp_valid", i_resp_valid, age >= 2 && !mdl_owner_d);
        chk("d_resp_valid", d_resp_valid, age >= 2 && mdl_owner_d);
        if (age >= 2 && !mdl_owner_d) begin
            chk("i_resp_instr", i_resp_instr, exp_instr);
            chk("i_resp_exc", i_resp_exc, exp_iexc);
        end
        if (age >= 2 && mdl_owner_d) begin
            chk("d_resp_data", d_resp_data, exp_ddata);
            chk("d_resp_exc", d_resp_exc, exp_dexc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [63:0] a, output logic [31:0] instr, output logic [1:0] exc);
        bit ok;
        i_req_valid = 1'b1; i_req_addr = a; i_resp_ready = 1'b1;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (i_req_ready) ok = 1;
        end
        chk("fetch_req_timeout", ok, 1'b1);
        tick();
        i_req_valid = 1'b0;
        ok = 0; instr = '0; exc = '0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (i_resp_valid) begin ok = 1; instr = i_resp_instr; exc = i_resp_exc; end
        end
        chk("fetch_resp_timeout", ok, 1'b1);
        tick();
    endtask

    task automatic dreq(input logic [63:0] a, input logic [63:0] wd, input logic [1:0] memo,
                        input logic [7:0] mask, output logic [63:0] rd, output logic [1:0] exc);
        bit ok;
        d_req_valid = 1'b1; d_req_addr = a; d_req_data = wd; d_req_memo = memo;
        d_req_mask = mask; d_resp_ready = 1'b1;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (d_req_ready) ok = 1;
        end
        chk("data_req_timeout", ok, 1'b1);
        tick();
        d_req_valid = 1'b0;
        ok = 0; rd = '0; exc = '0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (d_resp_valid) begin ok = 1; rd = d_resp_data; exc = d_resp_exc; end
        end
        chk("data_resp_timeout", ok, 1'b1);
        tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] instr;
        logic [1:0]  exc;
        logic [63:0] rd;
        logic [9:0]  order;
        int          grants;

        for (int k = 0; k < 1048576; k++) ram[k] = 8'h00;
        ram[20'h100] = 8'h13;
        for (int b = 0; b < 8; b++) ram[20'h40 + 20'(b)] = 8'hEF - 8'(b * 8'h22);

        reset = 1'b1;
        #2;
        chk("rst_m_enable", m_enable, 1'b0);
        chk("rst_i_resp_valid", i_resp_valid, 1'b0);
        chk("rst_d_resp_valid", d_resp_valid, 1'b0);
        chk("rst_m_addr", m_addr, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Fetch latency: ready at T, enable in T+1, response from T+2.
        i_req_valid = 1'b1; i_req_addr = 64'h100;
        @(negedge clk);
        chk("lat_i_req_ready", i_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        @(negedge clk);
        chk("lat_m_enable", m_enable, 1'b1);
        chk("lat_no_resp_yet", i_resp_valid, 1'b0);
        @(negedge clk);
        chk("lat_i_resp_valid", i_resp_valid, 1'b1);
        chk("lat_instr", i_resp_instr, 64'h13);
        chk("lat_exc", i_resp_exc, 2'b00);
        tick();

        // Masked store then load back.
        dreq(64'h80, 64'h1122334455667788, 2'b01, 8'h0F, rd, exc);
        chk("store_resp_data", rd, 64'd0);
        chk("store_resp_exc", exc, 2'b00);
        dreq(64'h80, 64'd0, 2'b00, 8'h00, rd, exc);
        chk("load_after_store", rd, 64'h0000000055667788);

        // Starvation guard with both sides permanently valid.
        do_reset();
        i_req_valid = 1'b1; i_req_addr = 64'h100;
        d_req_valid = 1'b1; d_req_addr = 64'h80; d_req_memo = 2'b00; d_req_mask = 8'h00;
        i_resp_ready = 1'b1; d_resp_ready = 1'b1;
        order = '0; grants = 0;
        for (int n = 0; n < 200 && grants < 10; n++) begin
            @(negedge clk);
            if (i_req_ready || d_req_ready) begin
                order = {order[8:0], d_req_ready};
                grants++;
            end
        end
        chk("starve_grant_count", 64'(grants), 64'd10);
        chk("starve_order", order, 10'b1111011110);
        tick();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (4) tick();

        // Exception paths.
        fetch(64'h8000_0001, instr, exc);
        chk("fetch_misaligned_exc", exc, 2'b01);
        fetch(64'h0010_0000, instr, exc);
        chk("fetch_oob_exc", exc, 2'b10);
        dreq(64'h1_0000_0000, 64'd0, 2'b00, 8'h00, rd, exc);
        chk("load_oob_exc", exc, 2'b10);

        // Response back-pressure: data response held while a fetch waits.
        d_resp_ready = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 64'h80; d_req_memo = 2'b00; d_req_mask = 8'h00;
        @(negedge clk);
        chk("bp_d_req_ready", d_req_ready, 1'b1);
        tick();
        d_req_valid = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 64'h100;
        tick();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_d_resp_valid", d_resp_valid, 1'b1);
            chk("bp_d_resp_data", d_resp_data, 64'h0000000055667788);
            chk("bp_i_req_ready", i_req_ready, 1'b0);
            if (n < 4) tick();
        end
        d_resp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_released_valid", d_resp_valid, 1'b0);
        chk("bp_fetch_granted", i_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        repeat (4) tick();

        // Reset during the ACCESS cycle of a store.
        d_req_valid = 1'b1; d_req_addr = 64'h40; d_req_data = 64'hDEADBEEFCAFEF00D;
        d_req_memo = 2'b01; d_req_mask = 8'hFF;
        @(negedge clk);
        chk("rst_store_ready", d_req_ready, 1'b1);
        tick();
        d_req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_m_enable", m_enable, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ram_unchanged", ram_peek(64'h40), 64'h0123456789ABCDEF);
        repeat (3) tick();
        dreq(64'h40, 64'd0, 2'b00, 8'h00, rd, exc);
        chk("rst_load_after", rd, 64'h0123456789ABCDEF);
        fetch(64'h100, instr, exc);
        chk("rst_fetch_after", instr, 64'h13);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
